// File: rtl/convert_op_if.sv
// rtl/convert_op_if.sv - sample-in / integer-out stream bundle for the FFT output converter
interface convert_op_if #(
  parameter int OUT_W = 16,
  parameter int LOG2N = 3
);
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      in_re;
  logic [31:0]      in_im;
  logic             out_valid;
  logic             out_ready;
  logic [OUT_W-1:0] out_re;
  logic [OUT_W-1:0] out_im;
  logic [LOG2N-1:0] out_idx;
  logic             out_last;
  logic             sat_flag;

  modport slave (
    input  in_valid, in_re, in_im, out_ready,
    output in_ready, out_valid, out_re, out_im, out_idx, out_last, sat_flag
  );

  modport master (
    output in_valid, in_re, in_im, out_ready,
    input  in_ready, out_valid, out_re, out_im, out_idx, out_last, sat_flag
  );
endinterface

// File: rtl/convert_op.sv
// rtl/convert_op.sv - FFT output converter: Q16.16 round/saturate, bit-reverse reorder, frame drain
module convert_op #(
  parameter int LENGTH = 8,
  parameter int LOG2N  = 3,
  parameter int OUT_W  = 16,
  parameter int BITREV = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  convert_op_if.slave  bus
);

  typedef enum logic {FILL, DRAIN} state_t;

  localparam logic [LOG2N-1:0]  LAST  = LOG2N'(LENGTH - 1);
  localparam logic signed [32:0] MAX_V = (33'sd1 <<< (OUT_W - 1)) - 33'sd1;
  localparam logic signed [32:0] MIN_V = -(33'sd1 <<< (OUT_W - 1));

  state_t           state;
  logic [LOG2N-1:0] wr_cnt;
  logic [LOG2N-1:0] rd_cnt;
  logic [LOG2N-1:0] rd_next;
  logic [LOG2N-1:0] wr_addr;
  logic             in_ready_r;
  logic             out_valid_r;
  logic             out_last_r;
  logic             sat_r;
  logic [OUT_W-1:0] out_re_r;
  logic [OUT_W-1:0] out_im_r;
  logic [OUT_W:0]   conv_re;
  logic [OUT_W:0]   conv_im;
  logic             accept;

  logic [OUT_W-1:0] mem_re [LENGTH];
  logic [OUT_W-1:0] mem_im [LENGTH];

  // Returns {saturated, value}; the 33-bit sum keeps 0x7FFFFFFF + 0x8000 from wrapping.
  function automatic logic [OUT_W:0] round_sat(input logic [31:0] x);
    logic signed [32:0] t;
    logic signed [32:0] y;
    t = $signed({x[31], x}) + 33'sd32768;
    y = t >>> 16;
    if (y > MAX_V)
      round_sat = {1'b1, MAX_V[OUT_W-1:0]};
    else if (y < MIN_V)
      round_sat = {1'b1, MIN_V[OUT_W-1:0]};
    else
      round_sat = {1'b0, y[OUT_W-1:0]};
  endfunction

  function automatic logic [LOG2N-1:0] map_addr(input logic [LOG2N-1:0] idx);
    logic [LOG2N-1:0] r;
    r = idx;
    if (BITREV != 0) begin
      for (int b = 0; b < LOG2N; b++)
        r[b] = idx[LOG2N-1-b];
    end
    return r;
  endfunction

  always_comb begin
    conv_re = round_sat(bus.in_re);
    conv_im = round_sat(bus.in_im);
    wr_addr = map_addr(wr_cnt);
    rd_next = rd_cnt + 1'b1;
    accept  = bus.in_valid && in_ready_r;
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      mem_re[wr_addr] <= conv_re[OUT_W-1:0];
      mem_im[wr_addr] <= conv_im[OUT_W-1:0];
    end
  end

  // The last arrival always lands at address LENGTH-1, so slot 0 is already valid when DRAIN starts.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= FILL;
      wr_cnt      <= '0;
      rd_cnt      <= '0;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
      out_last_r  <= 1'b0;
      out_re_r    <= '0;
      out_im_r    <= '0;
      sat_r       <= 1'b0;
    end else begin
      case (state)
        FILL: begin
          if (accept) begin
            sat_r <= sat_r | conv_re[OUT_W] | conv_im[OUT_W];
            if (wr_cnt == LAST) begin
              state       <= DRAIN;
              wr_cnt      <= '0;
              rd_cnt      <= '0;
              in_ready_r  <= 1'b0;
              out_valid_r <= 1'b1;
              out_last_r  <= 1'b0;
              out_re_r    <= mem_re[0];
              out_im_r    <= mem_im[0];
            end else begin
              wr_cnt <= wr_cnt + 1'b1;
            end
          end
        end
        DRAIN: begin
          if (out_valid_r && bus.out_ready) begin
            if (out_last_r) begin
              state       <= FILL;
              rd_cnt      <= '0;
              in_ready_r  <= 1'b1;
              out_valid_r <= 1'b0;
              out_last_r  <= 1'b0;
            end else begin
              rd_cnt     <= rd_next;
              out_last_r <= (rd_next == LAST);
              out_re_r   <= mem_re[rd_next];
              out_im_r   <= mem_im[rd_next];
            end
          end
        end
        default: state <= FILL;
      endcase
    end
  end

  assign bus.in_ready  = in_ready_r;
  assign bus.out_valid = out_valid_r;
  assign bus.out_re    = out_re_r;
  assign bus.out_im    = out_im_r;
  assign bus.out_idx   = rd_cnt;
  assign bus.out_last  = out_last_r;
  assign bus.sat_flag  = sat_r;

endmodule

// File: tb/tb_convert_op.sv
// tb/tb_convert_op.sv - randomized bench for convert_op, bit-reversed and natural-order instances side by side
module tb_convert_op;
  localparam int N     = 8;
  localparam int LOG2N = 3;
  localparam int OUT_W = 16;
  localparam int PW    = LOG2N + 1 + 2 * OUT_W;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [31:0] in_re = '0;
  logic [31:0] in_im = '0;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int first_hs = 0;
  bit sat_model = 0;
  logic [31:0] fr_re [N];
  logic [31:0] fr_im [N];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  convert_op_if #(.OUT_W(OUT_W), .LOG2N(LOG2N)) ifa ();
  convert_op_if #(.OUT_W(OUT_W), .LOG2N(LOG2N)) ifb ();

  assign ifa.in_valid  = in_valid;
  assign ifa.in_re     = in_re;
  assign ifa.in_im     = in_im;
  assign ifa.out_ready = out_ready;
  assign ifb.in_valid  = in_valid;
  assign ifb.in_re     = in_re;
  assign ifb.in_im     = in_im;
  assign ifb.out_ready = out_ready;

  convert_op #(.LENGTH(N), .LOG2N(LOG2N), .OUT_W(OUT_W), .BITREV(1)) dut_rev (
    .clk(clk), .rst_n(rst_n), .bus(ifa)
  );
  convert_op #(.LENGTH(N), .LOG2N(LOG2N), .OUT_W(OUT_W), .BITREV(0)) dut_nat (
    .clk(clk), .rst_n(rst_n), .bus(ifb)
  );

  function automatic int brev(int k);
    int r = 0;
    for (int i = 0; i < LOG2N; i++) begin
      r = r * 2 + (k % 2);
      k = k / 2;
    end
    return r;
  endfunction

  function automatic longint rnd(logic [31:0] x);
    longint v = longint'($signed(x));
    return (v + 32768) >>> 16;
  endfunction

  function automatic longint clampv(longint y);
    longint lim = longint'(1) << (OUT_W - 1);
    if (y > lim - 1) return lim - 1;
    if (y < -lim) return -lim;
    return y;
  endfunction

  function automatic logic [31:0] rand_val();
    case ($urandom_range(3))
      0: return $urandom;
      1: return {{7{1'b0}}, 25'($urandom)} - 32'h0100_0000;
      2: return 32'h7FFF_0000 | 32'($urandom_range(65535));
      default: return 32'h8000_0000 | 32'($urandom_range(65535));
    endcase
  endfunction

  task automatic send_frame(input int gap_pct, input int nacc);
    int k = 0;
    int guard = 0;
    while (k < nacc && guard < 500) begin
      @(negedge clk);
      guard++;
      if (int'($urandom_range(99)) < gap_pct) begin
        in_valid = 1'b0;
        in_re    = $urandom;
        in_im    = $urandom;
      end else begin
        in_valid = 1'b1;
        in_re    = fr_re[k];
        in_im    = fr_im[k];
        if (ifa.in_ready === 1'b1) begin
          if (k == 0) first_hs = cyc;
          if (clampv(rnd(fr_re[k])) != rnd(fr_re[k])) sat_model = 1;
          if (clampv(rnd(fr_im[k])) != rnd(fr_im[k])) sat_model = 1;
          k++;
        end
      end
    end
    if (k < nacc) begin
      errors++;
      $display("FAIL fill_timeout: accepted %0d samples, required %0d", k, nacc);
    end
  endtask

  task automatic drain_frame(input int mode);
    logic [PW-1:0] ea [N];
    logic [PW-1:0] eb [N];
    logic [PW-1:0] ga, gb;
    int j = 0;
    int guard = 0;
    int c = 0;
    for (int i = 0; i < N; i++) begin
      ea[i] = {LOG2N'(i), 1'(i == N - 1), OUT_W'(clampv(rnd(fr_re[brev(i)]))),
               OUT_W'(clampv(rnd(fr_im[brev(i)])))};
      eb[i] = {LOG2N'(i), 1'(i == N - 1), OUT_W'(clampv(rnd(fr_re[i]))),
               OUT_W'(clampv(rnd(fr_im[i])))};
    end
    while (j < N && guard < 200) begin
      @(negedge clk);
      guard++;
      if (guard == 1) begin
        checks++;
        if (ifa.out_valid !== 1'b1 || ifb.out_valid !== 1'b1) begin
          errors++;
          $display("FAIL first_valid: got %b/%b, required 1/1", ifa.out_valid, ifb.out_valid);
        end
      end
      checks++;
      if (ifa.in_ready !== 1'b0 || ifb.in_ready !== 1'b0) begin
        errors++;
        $display("FAIL drain_in_ready: got %b/%b, required 0/0", ifa.in_ready, ifb.in_ready);
      end
      if (ifa.out_valid === 1'b1 && ifb.out_valid === 1'b1) begin
        ga = {ifa.out_idx, ifa.out_last, ifa.out_re, ifa.out_im};
        gb = {ifb.out_idx, ifb.out_last, ifb.out_re, ifb.out_im};
        checks++;
        if (ga !== ea[j]) begin
          errors++;
          $display("FAIL data_bitrev slot %0d: got %h, required %h", j, ga, ea[j]);
        end
        checks++;
        if (gb !== eb[j]) begin
          errors++;
          $display("FAIL data_natural slot %0d: got %h, required %h", j, gb, eb[j]);
        end
      end
      case (mode)
        0:       out_ready = 1'b1;
        1:       out_ready = (c % 3 == 0);
        default: out_ready = 1'($urandom_range(1));
      endcase
      c++;
      in_valid = 1'($urandom_range(1));
      in_re    = $urandom;
      in_im    = $urandom;
      if (ifa.out_valid === 1'b1 && out_ready) j++;
    end
    if (j < N) begin
      errors++;
      $display("FAIL drain_timeout: emitted %0d outputs, required %0d", j, N);
    end
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b0;
    checks++;
    if (ifa.out_valid !== 1'b0 || ifb.out_valid !== 1'b0 ||
        ifa.in_ready !== 1'b1 || ifb.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL after_drain: valid %b/%b ready %b/%b, required valid 0 ready 1",
               ifa.out_valid, ifb.out_valid, ifa.in_ready, ifb.in_ready);
    end
  endtask

  task automatic check_sat(input string name);
    checks++;
    if (ifa.sat_flag !== sat_model || ifb.sat_flag !== sat_model) begin
      errors++;
      $display("FAIL %s: sat_flag got %b/%b, required %b", name, ifa.sat_flag, ifb.sat_flag, sat_model);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({ifa.out_valid, ifa.out_re, ifa.out_im, ifa.out_idx, ifa.out_last, ifa.sat_flag} !== '0 ||
        {ifb.out_valid, ifb.out_re, ifb.out_im, ifb.out_idx, ifb.out_last, ifb.sat_flag} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got valid %b re %h im %h idx %0d, required all zero",
               ifa.out_valid, ifa.out_re, ifa.out_im, ifa.out_idx);
    end
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (ifa.in_ready !== 1'b1 || ifb.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_in_ready: got %b/%b, required 1/1", ifa.in_ready, ifb.in_ready);
    end
  endtask

  task automatic test_order();
    for (int k = 0; k < N; k++) begin
      fr_re[k] = 32'(k) << 16;
      fr_im[k] = -(32'(k) << 16);
    end
    send_frame(0, N);
    drain_frame(0);
  endtask

  task automatic test_rounding();
    logic [31:0] vals [N];
    vals = '{32'h0001_8000, 32'h0001_7FFF, 32'hFFFE_8000, 32'hFFFF_7FFF,
             32'h0000_8000, 32'hFFFF_8000, 32'h0000_7FFF, 32'h0000_0000};
    for (int k = 0; k < N; k++) begin
      fr_re[k] = vals[k];
      fr_im[k] = vals[N - 1 - k];
    end
    send_frame(0, N);
    drain_frame(0);
    check_sat("rounding_no_sat");
  endtask

  task automatic test_saturation();
    for (int k = 0; k < N; k++) begin
      fr_re[k] = 32'($urandom_range(200)) << 16;
      fr_im[k] = -(32'($urandom_range(200)) << 16);
    end
    fr_re[2] = 32'h7FFF_FFFF;
    fr_im[5] = 32'h8000_0000;
    fr_re[6] = 32'h7FFF_8000;
    send_frame(0, N);
    drain_frame(0);
    check_sat("saturation_set");
  endtask

  task automatic test_backpressure();
    for (int k = 0; k < N; k++) begin
      fr_re[k] = 32'($urandom) >>> 12;
      fr_im[k] = 32'($urandom) >>> 12;
    end
    send_frame(0, N);
    drain_frame(1);
    check_sat("sat_sticky");
  endtask

  task automatic test_reset_midframe();
    for (int k = 0; k < N; k++) fr_re[k] = 32'h7FFF_FFFF;
    for (int k = 0; k < N; k++) fr_im[k] = 32'h0003_0000;
    send_frame(0, 5);
    @(negedge clk);
    in_valid = 1'b0;
    rst_n    = 1'b0;
    sat_model = 0;
    #2;
    checks++;
    if (ifa.out_valid !== 1'b0 || ifb.out_valid !== 1'b0 || ifa.sat_flag !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: valid %b/%b sat %b, required 0/0 sat 0",
               ifa.out_valid, ifb.out_valid, ifa.sat_flag);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) begin
      @(negedge clk);
      checks++;
      if (ifa.out_valid !== 1'b0 || ifb.out_valid !== 1'b0) begin
        errors++;
        $display("FAIL partial_frame_output: valid %b/%b, required 0/0", ifa.out_valid, ifb.out_valid);
      end
    end
    for (int k = 0; k < N; k++) begin
      fr_re[k] = 32'(k * 3 + 1) << 16;
      fr_im[k] = 32'($urandom) >>> 10;
    end
    send_frame(0, N);
    drain_frame(0);
    check_sat("reset_clears_sat");
  endtask

  task automatic test_random();
    int prev_hs = 0;
    for (int f = 0; f < 6; f++) begin
      for (int k = 0; k < N; k++) begin
        fr_re[k] = rand_val();
        fr_im[k] = rand_val();
      end
      send_frame(40, N);
      if (f > 0) begin
        checks++;
        if (first_hs - prev_hs < 2 * N) begin
          errors++;
          $display("FAIL frame_period: got %0d cycles, required >= %0d", first_hs - prev_hs, 2 * N);
        end
      end
      prev_hs = first_hs;
      drain_frame(2);
    end
    check_sat("random_sat");
  endtask

  initial begin
    test_reset();
    test_order();
    test_rounding();
    test_saturation();
    test_backpressure();
    test_reset_midframe();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
